clk_div_monitor: RTL

//  Receive-side checker for the integer clock dividers: samples a divided clock (i_div_clk) in the

---
 rtl/clk_div_monitor_pkg.sv | 15 +
 rtl/clk_div_monitor_if.sv | 24 ++
 rtl/clk_div_monitor_sync_2ff.sv | 23 ++
 rtl/clk_div_monitor.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/clk_div_monitor_pkg.sv
// Shared types and helpers for the divided-clock monitor.
// Holds the FSM state encoding and the derivation of the counter width.
package clk_div_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } mon_state_e;

  function automatic int cw_of(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/clk_div_monitor_if.sv
// Bundle of the divided clock under test and the measurement results.
// master = the monitor side, slave = whoever drives the clock and consumes results.
interface clk_div_monitor_if #(
  parameter int CW = 7
);
  logic          i_div_clk;
  logic [CW-1:0] o_high;
  logic [CW-1:0] o_low;
  logic [CW-1:0] o_period;
  logic          o_valid;
  logic          o_locked;
  logic          o_err;
  logic          o_stall;

  modport master (
    input  i_div_clk,
    output o_high, o_low, o_period, o_valid, o_locked, o_err, o_stall
  );

  modport slave (
    output i_div_clk,
    input  o_high, o_low, o_period, o_valid, o_locked, o_err, o_stall
  );
endinterface

// File: rtl/clk_div_monitor_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, reset value 0.
// Generic, so other CDC points can reuse it.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/clk_div_monitor.sv
// Measures high/low/period of a divided clock in source-clock cycles and
// reports lock, sticky ratio error and stall.
module clk_div_monitor
  import clk_div_monitor_pkg::*;
#(
  parameter int RATIO    = 8,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  clk_div_monitor_if.master  bus
);
  localparam int            CW    = cw_of(TIMEOUT);
  localparam int            GW    = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] CMAX  = '1;
  localparam logic [CW-1:0] TO_M1 = CW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GMAX  = GW'(LOCK_CNT);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + 1'b1;
  endfunction

  logic          w_sync;
  logic          r_s3;
  logic [1:0]    r_fill;
  logic          w_live, w_rise, w_fall, w_edge;
  logic [CW-1:0] r_idle;
  logic          w_stall_hit;
  mon_state_e    r_state, w_state_nxt;
  logic          w_publish;
  logic [CW-1:0] r_hcnt, r_lcnt;
  logic [CW:0]   w_sum;
  logic [CW-1:0] w_period;
  logic          w_good;
  logic [GW-1:0] r_gc, w_gc_inc;
  logic [CW-1:0] r_high, r_low, r_period;
  logic          r_valid, r_locked, r_err, r_stall;

  sync_2ff u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (bus.i_div_clk),
    .o_q     (w_sync)
  );

  // Edges are ignored until the sync chain and r_s3 hold real samples, so a
  // clock that is already high at reset release is not mistaken for a rise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s3   <= 1'b0;
      r_fill <= 2'd0;
    end else begin
      r_s3 <= w_sync;
      if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
    end
  end

  assign w_live      = (r_fill == 2'd3);
  assign w_rise      = w_live &  w_sync & ~r_s3;
  assign w_fall      = w_live & ~w_sync &  r_s3;
  assign w_edge      = w_rise | w_fall;
  assign w_stall_hit = ~w_edge & (r_idle == TO_M1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_idle <= '0;
    else if (w_edge) r_idle <= '0;
    else             r_idle <= sat_inc(r_idle);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_publish   = 1'b0;
    if (w_stall_hit) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_rise) w_state_nxt = ST_HIGH;
        ST_HIGH: if (w_fall) w_state_nxt = ST_LOW;
        ST_LOW: begin
          if (w_rise) begin
            w_state_nxt = ST_HIGH;
            w_publish   = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Phase counters start at 1 on the detection cycle, so a clean 8:1 reads 4/4.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hcnt <= '0;
      r_lcnt <= '0;
    end else if (w_stall_hit) begin
      r_hcnt <= '0;
      r_lcnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_hcnt <= CW'(1);
            r_lcnt <= '0;
          end
        end
        ST_HIGH: begin
          if (w_fall) r_lcnt <= CW'(1);
          else        r_hcnt <= sat_inc(r_hcnt);
        end
        ST_LOW: begin
          if (w_rise) begin
            r_hcnt <= CW'(1);
            r_lcnt <= '0;
          end else begin
            r_lcnt <= sat_inc(r_lcnt);
          end
        end
        default: begin
          r_hcnt <= '0;
          r_lcnt <= '0;
        end
      endcase
    end
  end

  assign w_sum    = {1'b0, r_hcnt} + {1'b0, r_lcnt};
  assign w_period = w_sum[CW] ? CMAX : w_sum[CW-1:0];
  assign w_good   = (int'(w_period) >= RATIO - TOL) && (int'(w_period) <= RATIO + TOL);
  assign w_gc_inc = (r_gc == GMAX) ? GMAX : r_gc + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_high   <= '0;
      r_low    <= '0;
      r_period <= '0;
      r_valid  <= 1'b0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
      r_stall  <= 1'b0;
      r_gc     <= '0;
    end else begin
      r_valid <= w_publish;
      if (w_publish) begin
        r_high   <= r_hcnt;
        r_low    <= r_lcnt;
        r_period <= w_period;
        if (w_good) begin
          r_gc     <= w_gc_inc;
          r_locked <= (w_gc_inc == GMAX);
        end else begin
          r_gc     <= '0;
          r_locked <= 1'b0;
          r_err    <= 1'b1;
        end
      end
      if (w_stall_hit) begin
        r_stall  <= 1'b1;
        r_locked <= 1'b0;
        r_gc     <= '0;
      end else if (w_edge) begin
        r_stall <= 1'b0;
      end
    end
  end

  assign bus.o_high   = r_high;
  assign bus.o_low    = r_low;
  assign bus.o_period = r_period;
  assign bus.o_valid  = r_valid;
  assign bus.o_locked = r_locked;
  assign bus.o_err    = r_err;
  assign bus.o_stall  = r_stall;
endmodule
